// File: rtl/alu_share_arbiter_if.sv
// Handshake bundle between two ALU requesters, the shared arbiter and the ALU itself.
// The requesters/ALU side is the master; the arbiter is the slave.
interface alu_share_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 6
);
   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic [OP_W-1:0]   req0_aluc;
   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic [OP_W-1:0]   req1_aluc;

   logic              rsp0_valid;
   logic              rsp0_ready;
   logic [DATA_W-1:0] rsp0_result;
   logic              rsp0_zero;
   logic              rsp1_valid;
   logic              rsp1_ready;
   logic [DATA_W-1:0] rsp1_result;
   logic              rsp1_zero;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_aluc;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;

   modport master (
      output req0_valid, req0_a, req0_b, req0_aluc,
      output req1_valid, req1_a, req1_b, req1_aluc,
      output rsp0_ready, rsp1_ready,
      output alu_result, alu_zero,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_result, rsp0_zero,
      input  rsp1_valid, rsp1_result, rsp1_zero,
      input  alu_a, alu_b, alu_aluc
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_aluc,
      input  req1_valid, req1_a, req1_b, req1_aluc,
      input  rsp0_ready, rsp1_ready,
      input  alu_result, alu_zero,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_result, rsp0_zero,
      output rsp1_valid, rsp1_result, rsp1_zero,
      output alu_a, alu_b, alu_aluc
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One op in flight: IDLE (accept) -> EXEC (capture ALU output) -> RESP (hold until taken).
module alu_share_arbiter #(
   parameter int DATA_W  = 32,
   parameter int OP_W    = 6,
   parameter bit RR_INIT = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   alu_share_arbiter_if.slave  bus,
   output logic                busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            state_r;
   state_t            next_state_s;
   logic              prio_r;
   logic              owner_r;
   logic [DATA_W-1:0] a_r;
   logic [DATA_W-1:0] b_r;
   logic [OP_W-1:0]   aluc_r;
   logic [DATA_W-1:0] result_r;
   logic              zero_r;

   logic              grant_s;
   logic              accept_s;
   logic              req0_ready_s;
   logic              req1_ready_s;
   logic              rsp_take_s;

   // Next-state, grant selection and request-side ready
   always_comb begin
      next_state_s = state_r;
      grant_s      = prio_r;
      accept_s     = 1'b0;
      req0_ready_s = 1'b0;
      req1_ready_s = 1'b0;
      rsp_take_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.req0_valid && bus.req1_valid) begin
               grant_s = prio_r;
            end else if (bus.req1_valid) begin
               grant_s = 1'b1;
            end else begin
               grant_s = 1'b0;
            end
            if (!flush && (bus.req0_valid || bus.req1_valid)) begin
               accept_s     = 1'b1;
               req0_ready_s = ~grant_s;
               req1_ready_s = grant_s;
               next_state_s = ST_EXEC;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            next_state_s = ST_RESP;
         end
         ST_RESP: begin
            // Only the owner's ready completes the response; the other port is ignored
            rsp_take_s = owner_r ? bus.rsp1_ready : bus.rsp0_ready;
            if (rsp_take_s) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_RESP;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
      if (flush) begin
         next_state_s = ST_IDLE;
      end else begin
         next_state_s = next_state_s;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Round-robin pointer and owner move only on an accepted request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_r  <= RR_INIT;
         owner_r <= 1'b0;
      end else if (accept_s) begin
         prio_r  <= ~grant_s;
         owner_r <= grant_s;
      end
   end

   // Operand/op latch; feeds the ALU so no request input reaches alu_* combinationally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r    <= {DATA_W{1'b0}};
         b_r    <= {DATA_W{1'b0}};
         aluc_r <= {OP_W{1'b0}};
      end else if (accept_s) begin
         a_r    <= grant_s ? bus.req1_a    : bus.req0_a;
         b_r    <= grant_s ? bus.req1_b    : bus.req0_b;
         aluc_r <= grant_s ? bus.req1_aluc : bus.req0_aluc;
      end
   end

   // Result capture at the end of the single EXEC cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_r <= {DATA_W{1'b0}};
         zero_r   <= 1'b0;
      end else if ((state_r == ST_EXEC) && !flush) begin
         result_r <= bus.alu_result;
         zero_r   <= bus.alu_zero;
      end
   end

   // Ready is forced low while reset is held, even though IDLE grant is combinational
   assign bus.req0_ready  = req0_ready_s & rst_n;
   assign bus.req1_ready  = req1_ready_s & rst_n;

   assign bus.rsp0_valid  = (state_r == ST_RESP) && !owner_r;
   assign bus.rsp1_valid  = (state_r == ST_RESP) &&  owner_r;
   assign bus.rsp0_result = result_r;
   assign bus.rsp1_result = result_r;
   assign bus.rsp0_zero   = zero_r;
   assign bus.rsp1_zero   = zero_r;

   assign bus.alu_a    = a_r;
   assign bus.alu_b    = b_r;
   assign bus.alu_aluc = aluc_r;

   assign busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small add/sub/and ALU model on the ALU side.
module tb_alu_share_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   logic busy;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] alu_res_v;

   alu_share_arbiter_if #(.DATA_W(32), .OP_W(6)) bus ();

   alu_share_arbiter #(.DATA_W(32), .OP_W(6), .RR_INIT(1'b0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      case (bus.alu_aluc)
         6'h00:   alu_res_v = bus.alu_a + bus.alu_b;
         6'h08:   alu_res_v = bus.alu_a - bus.alu_b;
         default: alu_res_v = bus.alu_a & bus.alu_b;
      endcase
   end
   assign bus.alu_result = alu_res_v;
   assign bus.alu_zero   = (alu_res_v == 32'd0);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req0_aluc = 6'h00;
      bus.req1_valid = 1'b0; bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_aluc = 6'h00;
      bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

      // 1: reset state, request already valid but not accepted
      bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd7; bus.req0_aluc = 6'h00;
      #12;
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
      chk("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
      chk("rst_req0_ready", bus.req0_ready, 1'b0);
      chk("rst_req1_ready", bus.req1_ready, 1'b0);
      @(negedge clk); rst_n = 1'b1; #1;
      chk("rel_req0_ready", bus.req0_ready, 1'b1);
      chk("rel_req1_ready", bus.req1_ready, 1'b0);

      // 2: single add on port 0, response held for 3 cycles
      @(negedge clk); bus.req0_valid = 1'b0; #1;
      chk("exec_busy", busy, 1'b1);
      chk("exec_req0_ready", bus.req0_ready, 1'b0);
      chk("exec_rsp0_valid", bus.rsp0_valid, 1'b0);
      chk("exec_alu_a", bus.alu_a, 32'd5);
      chk("exec_alu_b", bus.alu_b, 32'd7);
      @(negedge clk); #1;
      chk("add_rsp0_valid", bus.rsp0_valid, 1'b1);
      chk("add_rsp0_result", bus.rsp0_result, 32'd12);
      chk("add_rsp0_zero", bus.rsp0_zero, 1'b0);
      chk("add_rsp1_valid", bus.rsp1_valid, 1'b0);
      repeat (3) begin
         @(negedge clk); #1;
         chk("hold_rsp0_valid", bus.rsp0_valid, 1'b1);
         chk("hold_rsp0_result", bus.rsp0_result, 32'd12);
         chk("hold_alu_a", bus.alu_a, 32'd5);
      end
      bus.rsp0_ready = 1'b1;
      @(negedge clk); bus.rsp0_ready = 1'b0; #1;
      chk("add_done_rsp0_valid", bus.rsp0_valid, 1'b0);
      chk("add_done_busy", busy, 1'b0);

      // 3: sub on port 1 sets zero; ready on port 0 is ignored
      bus.req1_valid = 1'b1; bus.req1_a = 32'd5; bus.req1_b = 32'd5; bus.req1_aluc = 6'h08; #1;
      chk("sub_req1_ready", bus.req1_ready, 1'b1);
      chk("sub_req0_ready", bus.req0_ready, 1'b0);
      @(negedge clk); bus.req1_valid = 1'b0; bus.rsp0_ready = 1'b1; #1;
      chk("sub_exec_rsp1_valid", bus.rsp1_valid, 1'b0);
      @(negedge clk); #1;
      chk("sub_rsp1_valid", bus.rsp1_valid, 1'b1);
      chk("sub_rsp1_result", bus.rsp1_result, 32'd0);
      chk("sub_rsp1_zero", bus.rsp1_zero, 1'b1);
      chk("sub_rsp0_valid", bus.rsp0_valid, 1'b0);
      @(negedge clk); bus.rsp0_ready = 1'b0; #1;
      chk("sub_nonowner_ignored", bus.rsp1_valid, 1'b1);
      bus.rsp1_ready = 1'b1;
      @(negedge clk); bus.rsp1_ready = 1'b0; #1;
      chk("sub_done_rsp1_valid", bus.rsp1_valid, 1'b0);
      chk("sub_done_busy", busy, 1'b0);

      // 4: continuous contention, grants alternate 0,1,0,1
      bus.req0_valid = 1'b1; bus.req0_a = 32'd10; bus.req0_b = 32'd3; bus.req0_aluc = 6'h00;
      bus.req1_valid = 1'b1; bus.req1_a = 32'd10; bus.req1_b = 32'd3; bus.req1_aluc = 6'h08;
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_req0_ready", bus.req0_ready, (i % 2) == 0);
         chk("rr_req1_ready", bus.req1_ready, (i % 2) == 1);
         @(negedge clk);
         @(negedge clk); #1;
         chk("rr_rsp0_valid", bus.rsp0_valid, (i % 2) == 0);
         chk("rr_rsp1_valid", bus.rsp1_valid, (i % 2) == 1);
         chk("rr_result", bus.rsp0_result, ((i % 2) == 0) ? 32'd13 : 32'd7);
         @(negedge clk);
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

      // 5: flush in IDLE blocks accept, flush in EXEC and RESP aborts
      bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_aluc = 6'h00;
      flush = 1'b1; #1;
      chk("flush_idle_req0_ready", bus.req0_ready, 1'b0);
      @(negedge clk); flush = 1'b0; #1;
      chk("flush_idle_busy", busy, 1'b0);
      chk("flush_idle_req0_ready_after", bus.req0_ready, 1'b1);
      @(negedge clk); bus.req0_valid = 1'b0; flush = 1'b1; #1;
      chk("flush_exec_busy", busy, 1'b1);
      @(negedge clk); flush = 1'b0; #1;
      chk("flush_exec_busy_after", busy, 1'b0);
      chk("flush_exec_rsp0_valid", bus.rsp0_valid, 1'b0);
      @(negedge clk); #1;
      chk("flush_exec_no_late_rsp", bus.rsp0_valid, 1'b0);
      bus.req0_valid = 1'b1; #1;
      chk("flush_resp_accept", bus.req0_ready, 1'b1);
      @(negedge clk); bus.req0_valid = 1'b0;
      @(negedge clk); #1;
      chk("flush_resp_rsp0_valid", bus.rsp0_valid, 1'b1);
      chk("flush_resp_result", bus.rsp0_result, 32'd3);
      flush = 1'b1;
      @(negedge clk); flush = 1'b0; #1;
      chk("flush_resp_rsp0_valid_after", bus.rsp0_valid, 1'b0);
      chk("flush_resp_busy_after", busy, 1'b0);
      // prio survived the flushes and points at port 1
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1; bus.req1_a = 32'd9; bus.req1_b = 32'd4; bus.req1_aluc = 6'h08; #1;
      chk("post_flush_req1_ready", bus.req1_ready, 1'b1);
      chk("post_flush_req0_ready", bus.req0_ready, 1'b0);
      @(negedge clk); bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      @(negedge clk); #1;
      chk("post_flush_rsp1_valid", bus.rsp1_valid, 1'b1);
      chk("post_flush_rsp1_result", bus.rsp1_result, 32'd5);
      chk("post_flush_rsp1_zero", bus.rsp1_zero, 1'b0);
      bus.rsp1_ready = 1'b1;
      @(negedge clk); bus.rsp1_ready = 1'b0; #1;
      chk("post_flush_done", bus.rsp1_valid, 1'b0);

      // 6: async reset during RESP
      bus.req0_valid = 1'b1; bus.req0_a = 32'd3; bus.req0_b = 32'd3; bus.req0_aluc = 6'h00; #1;
      chk("ar_accept", bus.req0_ready, 1'b1);
      @(negedge clk); bus.req0_valid = 1'b0;
      @(negedge clk); #1;
      chk("ar_rsp0_valid", bus.rsp0_valid, 1'b1);
      chk("ar_rsp0_result", bus.rsp0_result, 32'd6);
      #2 rst_n = 1'b0; #1;
      chk("ar_rsp0_valid_dropped", bus.rsp0_valid, 1'b0);
      chk("ar_busy", busy, 1'b0);
      chk("ar_alu_a", bus.alu_a, 32'd0);
      chk("ar_rsp0_result_cleared", bus.rsp0_result, 32'd0);
      @(negedge clk); rst_n = 1'b1; bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; #1;
      chk("ar_prio_req0_ready", bus.req0_ready, 1'b1);
      chk("ar_prio_req1_ready", bus.req1_ready, 1'b0);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
